// File: rtl/arm_pkg.sv
// Shared definitions for the instruction encoder: op-type encodings,
// data-processing command codes, the always-execute condition and the
// instruction-memory writer state enum.
package arm_pkg;

  // Two-bit op field carried straight into word bits [27:26]
  typedef enum logic [1:0] {
    OP_DP     = 2'b00,
    OP_MEM    = 2'b01,
    OP_BRANCH = 2'b10,
    OP_RSV    = 2'b11
  } opType_e;

  // Data-processing commands the encoder knows about
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Condition code meaning "always execute"
  localparam logic [3:0] COND_AL = 4'b1110;

  // Register number that doubles as the program counter
  localparam logic [3:0] REG_PC = 4'b1111;

  // Buffer entry = {last tag, encoded word}
  localparam int WORD_W  = 32;
  localparam int ENTRY_W = WORD_W + 1;

  // Byte stride between consecutive instruction words
  localparam logic [31:0] ADDR_STRIDE = 32'd4;

  // Writer FSM: wait for start, stream words out, pulse done
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } wrState_e;

  // True when the command is one of the four supported DP operations
  function automatic logic isSupportedCmd(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded words with their last tag.
// Read data is presented combinationally from the head entry; a push on a
// full buffer is dropped even when a pop happens in the same cycle.
module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CNT_W'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push & ~o_full;
  assign w_doPop  = i_pop & ~o_empty;
  assign o_rdata  = r_mem[r_rdPtr];

  // Storage array; contents need no reset because the count gates reads
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_wdata;
    end
  end

  // Pointers and occupancy; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: packs field sets into 32-bit instruction words,
// buffers them in enc_fifo and streams them into instruction memory at
// consecutive word addresses once started.
// Optional feature macro: ENC_ILLEGAL_CHECK_EN -- when defined, err latches
// on acceptance of a reserved op type, an unsupported DP command, or a
// flag-setting DP write to the PC; when undefined, err is tied low.
module instr_encoder
  import arm_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_type,
  input  logic [3:0]  in_cond,
  input  logic [3:0]  in_cmd,
  input  logic        in_i,
  input  logic        in_s,
  input  logic        in_l,
  input  logic [3:0]  in_rn,
  input  logic [3:0]  in_rd,
  input  logic [11:0] in_src2,
  input  logic [23:0] in_imm24,
  input  logic        in_last,
  input  logic        start,
  input  logic [31:0] base_addr,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wd,
  output logic        busy,
  output logic        done,
  output logic        err
);

  wrState_e           r_state;
  wrState_e           w_nextState;
  logic [31:0]        r_nextAddr;
  logic [WORD_W-1:0]  w_word;
  logic               w_accept;
  logic               w_pop;
  logic               w_popLast;
  logic               w_fifoFull;
  logic               w_fifoEmpty;
  logic [ENTRY_W-1:0] w_fifoRdata;

  assign in_ready  = ~w_fifoFull;
  assign w_accept  = in_valid & in_ready;
  assign w_pop     = (r_state == ST_RUN) & ~w_fifoEmpty;
  assign w_popLast = w_pop & w_fifoRdata[ENTRY_W-1];

  // Field packing; reserved op type falls through to the DP layout
  always_comb begin
    w_word = '0;
    case (opType_e'(in_type))
      OP_MEM:    w_word = {in_cond, in_type, ~in_i, 1'b1, 1'b1, 1'b0, 1'b0, in_l,
                           in_rn, in_rd, in_src2};
      OP_BRANCH: w_word = {in_cond, 3'b101, in_l, in_imm24};
      default:   w_word = {in_cond, in_type, in_i, in_cmd, in_s,
                           in_rn, in_rd, in_src2};
    endcase
  end

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_accept),
    .i_wdata ({in_last, w_word}),
    .i_pop   (w_pop),
    .o_rdata (w_fifoRdata),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  // Writer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Writer next-state: the run ends on the pop of a last-tagged word
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: if (start) w_nextState = ST_RUN;
      ST_RUN:  if (w_popLast) w_nextState = ST_DONE;
      ST_DONE: w_nextState = ST_IDLE;
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Writer status outputs decoded from state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Next write address: loaded on start from idle, stepped once per pop
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nextAddr <= '0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_nextAddr <= base_addr;
    end else if (w_pop) begin
      r_nextAddr <= r_nextAddr + ADDR_STRIDE;
    end
  end

  // Registered memory write port, one word per popped entry
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we   <= 1'b0;
      imem_addr <= '0;
      imem_wd   <= '0;
    end else begin
      imem_we <= w_pop;
      if (w_pop) begin
        imem_addr <= r_nextAddr;
        imem_wd   <= w_fifoRdata[WORD_W-1:0];
      end
    end
  end

`ifdef ENC_ILLEGAL_CHECK_EN
  logic w_illegal;
  logic r_err;

  // Flags field sets the encoder will still emit but that are not legal
  always_comb begin
    w_illegal = 1'b0;
    case (opType_e'(in_type))
      OP_RSV: w_illegal = 1'b1;
      OP_DP:  w_illegal = ~isSupportedCmd(in_cmd) | (in_s & (in_rd == REG_PC));
      default: w_illegal = 1'b0;
    endcase
  end

  // Sticky error, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven field sets feed a
// scoreboard of expected {address, word} pairs that is consumed whenever the
// DUT asserts imem_we; hand sequences cover latency, full buffer, address
// wrap and mid-run reset. Honours ENC_ILLEGAL_CHECK_EN for the err output.
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int FIFO_DEPTH = 4;
`ifdef ENC_ILLEGAL_CHECK_EN
  localparam logic EXP_ERR_AFTER_RSV = 1'b1;
`else
  localparam logic EXP_ERR_AFTER_RSV = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [3:0]  in_cond;
  logic [3:0]  in_cmd;
  logic        in_i;
  logic        in_s;
  logic        in_l;
  logic [3:0]  in_rn;
  logic [3:0]  in_rd;
  logic [11:0] in_src2;
  logic [23:0] in_imm24;
  logic        in_last;
  logic        start;
  logic [31:0] base_addr;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wd;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_cond   (in_cond),
    .in_cmd    (in_cmd),
    .in_i      (in_i),
    .in_s      (in_s),
    .in_l      (in_l),
    .in_rn     (in_rn),
    .in_rd     (in_rd),
    .in_src2   (in_src2),
    .in_imm24  (in_imm24),
    .in_last   (in_last),
    .start     (start),
    .base_addr (base_addr),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  cond;
    logic [3:0]  cmd;
    logic        fi;
    logic        fs;
    logic        fl;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [11:0] src2;
    logic [23:0] imm24;
    logic [31:0] expWd;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
  } exp_t;

  exp_t        sbQueue[$];
  int          writeCycles[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          doneCount = 0;
  logic [31:0] nextExpAddr = 32'h0;
  vec_t        tbl[7];

  function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] cond,
                              input logic [3:0] cmd, input logic fi, input logic fs,
                              input logic fl, input logic [3:0] rn, input logic [3:0] rd,
                              input logic [11:0] src2, input logic [23:0] imm24,
                              input logic [31:0] expWd);
    vec_t v;
    v.typ = typ; v.cond = cond; v.cmd = cmd; v.fi = fi; v.fs = fs; v.fl = fl;
    v.rn = rn; v.rd = rd; v.src2 = src2; v.imm24 = imm24; v.expWd = expWd;
    return v;
  endfunction

  // One clock; samples 1ns after the edge and consumes the scoreboard on writes
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    if (imem_we === 1'b1) begin
      writeCycles.push_back(cycle);
      checks++;
      if (sbQueue.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %h wd %h, required no write",
                 imem_addr, imem_wd);
      end else begin
        e = sbQueue.pop_front();
        if (imem_addr !== e.addr || imem_wd !== e.wd) begin
          errors++;
          $display("[TB] FAIL imem_write: got addr %h wd %h, required addr %h wd %h",
                   imem_addr, imem_wd, e.addr, e.wd);
        end
      end
    end
    if (done === 1'b1) doneCount++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic driveFields(input vec_t v, input logic last);
    in_type = v.typ; in_cond = v.cond; in_cmd = v.cmd; in_i = v.fi; in_s = v.fs;
    in_l = v.fl; in_rn = v.rn; in_rd = v.rd; in_src2 = v.src2; in_imm24 = v.imm24;
    in_last = last;
    in_valid = 1'b1;
  endtask

  // Present one field set, wait (bounded) for ready, record expectation on accept
  task automatic applyStimulus(input vec_t v, input logic last, input bit expectWrite);
    int n = 0;
    exp_t e;
    driveFields(v, last);
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready %b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    if (expectWrite) begin
      e.addr = nextExpAddr;
      e.wd   = v.expWd;
      sbQueue.push_back(e);
      nextExpAddr = nextExpAddr + 32'd4;
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic startRun(input logic [31:0] base);
    base_addr = base;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for all expected writes, then let the writer settle back to idle
  task automatic waitDrain();
    int n = 0;
    while (sbQueue.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (sbQueue.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending writes, required 0", sbQueue.size());
      sbQueue.delete();
    end
    repeat (4) tick();
  endtask

  int doneBefore;
  int wcBase;

  initial begin
    // Spec vectors and extra encodings, expected words derived by hand
    tbl[0] = mk(2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 12'h008, 24'h0, 32'hE5810008); // STR R0,[R1,#8]
    tbl[1] = mk(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 12'h000, 24'h000002, 32'hEA000002); // B +2
    tbl[2] = mk(2'b00, 4'hE, 4'hC, 1'b1, 1'b0, 1'b0, 4'd6, 4'd5, 12'h0FF, 24'h0, 32'hE38650FF); // ORR R5,R6,#FF
    tbl[3] = mk(2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 4'd8, 4'd7, 12'h009, 24'h0, 32'h00187009); // ANDEQS R7,R8,R9
    tbl[4] = mk(2'b11, 4'hE, 4'h4, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 12'h003, 24'h0, 32'hEC812003); // reserved type
    tbl[5] = mk(2'b10, 4'hA, 4'hF, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 12'hFFF, 24'hFFFFFE, 32'hABFFFFFE); // BLGE -2
    tbl[6] = mk(2'b01, 4'hE, 4'hF, 1'b0, 1'b1, 1'b1, 4'd3, 4'd4, 12'h005, 24'h0, 32'hE7934005); // LDR reg offset

    reset = 1'b1; in_valid = 1'b0; in_type = '0; in_cond = '0; in_cmd = '0;
    in_i = 1'b0; in_s = 1'b0; in_l = 1'b0; in_rn = '0; in_rd = '0; in_src2 = '0;
    in_imm24 = '0; in_last = 1'b0; start = 1'b0; base_addr = '0;

    // Reset state
    tick();
    tick();
    checkOutput("rst_imem_we", {31'b0, imem_we}, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_imem_wd", imem_wd, 32'h0);
    checkOutput("rst_busy", {31'b0, busy}, 32'h0);
    checkOutput("rst_done", {31'b0, done}, 32'h0);
    checkOutput("rst_err", {31'b0, err}, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("rst_in_ready", {31'b0, in_ready}, 32'h1);

    // ADD R1,R2,#5 with two-cycle accept-to-write latency
    nextExpAddr = 32'h0;
    startRun(32'h0);
    checkOutput("run_busy", {31'b0, busy}, 32'h1);
    doneBefore = doneCount;
    driveFields(mk(2'b00, 4'hE, 4'h4, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 12'h005, 24'h0, 32'h0), 1'b1);
    sbQueue.push_back('{addr: 32'h0, wd: 32'hE2821005});
    tick();
    in_valid = 1'b0;
    in_last = 1'b0;
    checkOutput("latency_cycle1_we", {31'b0, imem_we}, 32'h0);
    tick();
    checkOutput("latency_cycle2_we", {31'b0, imem_we}, 32'h1);
    repeat (4) tick();
    checkOutput("add_done_pulses", doneCount - doneBefore, 32'd1);
    checkOutput("add_busy_after", {31'b0, busy}, 32'h0);

    // SUBS then LDR last at 0x100; a start during RUN must be ignored
    nextExpAddr = 32'h100;
    doneBefore = doneCount;
    startRun(32'h100);
    startRun(32'h900);
    applyStimulus(mk(2'b00, 4'hE, 4'h2, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 12'h004, 24'h0, 32'hE0533004), 1'b0, 1'b1);
    applyStimulus(mk(2'b01, 4'hE, 4'h0, 1'b1, 1'b0, 1'b1, 4'd1, 4'd0, 12'h008, 24'h0, 32'hE5910008), 1'b1, 1'b1);
    waitDrain();
    checkOutput("subs_ldr_done_pulses", doneCount - doneBefore, 32'd1);
    checkOutput("subs_ldr_busy_after", {31'b0, busy}, 32'h0);
    checkOutput("subs_ldr_done_after", {31'b0, done}, 32'h0);

    // Table run, back-to-back presentation
    nextExpAddr = 32'h200;
    doneBefore = doneCount;
    startRun(32'h200);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(tbl[k], (k == 6), 1'b1);
    end
    waitDrain();
    checkOutput("table_done_pulses", doneCount - doneBefore, 32'd1);
    checkOutput("err_after_reserved", {31'b0, err}, {31'b0, EXP_ERR_AFTER_RSV});

    // Fill the buffer in IDLE, fifth word waits for space after start
    nextExpAddr = 32'h300;
    doneBefore = doneCount;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(tbl[k], 1'b0, 1'b1);
    end
    checkOutput("ready_low_when_full", {31'b0, in_ready}, 32'h0);
    wcBase = writeCycles.size();
    driveFields(tbl[5], 1'b1);
    base_addr = 32'h300;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("ready_low_full_at_start", {31'b0, in_ready}, 32'h0);
    applyStimulus(tbl[5], 1'b1, 1'b1);
    waitDrain();
    checkOutput("full_write_count", writeCycles.size() - wcBase, 32'd5);
    if (writeCycles.size() - wcBase >= 4) begin
      checkOutput("full_writes_consecutive", writeCycles[wcBase + 3] - writeCycles[wcBase], 32'd3);
    end
    checkOutput("full_done_pulses", doneCount - doneBefore, 32'd1);
    checkOutput("err_sticky", {31'b0, err}, {31'b0, EXP_ERR_AFTER_RSV});

    // Address wrap at the top of the address space
    nextExpAddr = 32'hFFFFFFFC;
    startRun(32'hFFFFFFFC);
    applyStimulus(tbl[2], 1'b0, 1'b1);
    applyStimulus(tbl[6], 1'b1, 1'b1);
    waitDrain();
    checkOutput("wrap_addr_hold", imem_addr, 32'h0);

    // Reset mid-RUN with three words buffered: nothing may be written
    for (int k = 0; k < 3; k++) begin
      applyStimulus(tbl[k], 1'b0, 1'b0);
    end
    startRun(32'h400);
    reset = 1'b1;
    tick();
    checkOutput("midrst_imem_we", {31'b0, imem_we}, 32'h0);
    checkOutput("midrst_busy", {31'b0, busy}, 32'h0);
    checkOutput("midrst_done", {31'b0, done}, 32'h0);
    checkOutput("midrst_addr", imem_addr, 32'h0);
    checkOutput("midrst_wd", imem_wd, 32'h0);
    checkOutput("midrst_err", {31'b0, err}, 32'h0);
    reset = 1'b0;
    tick();
    checkOutput("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (5) tick();

    // Buffer must be empty: a new run writes only its own word
    nextExpAddr = 32'h500;
    doneBefore = doneCount;
    startRun(32'h500);
    applyStimulus(tbl[1], 1'b1, 1'b1);
    waitDrain();
    checkOutput("post_rst_done_pulses", doneCount - doneBefore, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
